// File: rtl/alu_pkg.sv
// Shared constants, FSM encoding and helpers for the ALU self-test sequencer.
package alu_pkg;

  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned NUM_IDX = 32;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCheck,
    StDone
  } state_e;

  // Which ALU flags are meaningful for the current opcode.
  typedef struct packed {
    logic ovf;
    logic ne;
    logic lt;
  } chk_mask_t;

  // 32-bit rotate left by 0..31.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU: expected result and flags plus a mask of the
// flags that are defined for the given opcode.
module alu_golden
  import alu_pkg::*;
(
  input  logic [4:0]  opcode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] exp_result_o,
  output logic        exp_ovf_o,
  output logic        exp_ne_o,
  output logic        exp_lt_o,
  output chk_mask_t   chk_mask_o
);

  logic [31:0] sum;
  logic [31:0] diff;

  // Reference result and flags for the applied vector.
  always_comb begin
    sum          = a_i + b_i;
    diff         = a_i - b_i;
    exp_result_o = '0;
    exp_ovf_o    = 1'b0;
    // Relational flags come from a true signed compare, not the subtractor sign.
    exp_ne_o     = (a_i != b_i);
    exp_lt_o     = ($signed(a_i) < $signed(b_i));
    chk_mask_o   = '0;
    case (opcode_i)
      ALU_ADD: begin
        exp_result_o   = sum;
        exp_ovf_o      = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
        chk_mask_o.ovf = 1'b1;
      end
      ALU_SUB: begin
        exp_result_o   = diff;
        exp_ovf_o      = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
        chk_mask_o.ovf = 1'b1;
        chk_mask_o.ne  = 1'b1;
        chk_mask_o.lt  = 1'b1;
      end
      ALU_AND: exp_result_o = a_i & b_i;
      ALU_OR:  exp_result_o = a_i | b_i;
      ALU_SLL: exp_result_o = a_i << shamt_i;
      ALU_SRA: exp_result_o = 32'($signed(a_i) >>> shamt_i);
      default: exp_result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer. Walks rotated operand patterns through
// every opcode, compares the ALU outputs against alu_golden and records the
// number of failing vectors and the first one that failed.
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED_A        = 32'h8000_0001,
  parameter logic [31:0] SEED_B        = 32'h7FFF_FFFF,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic [4:0]       first_fail_op,
  output logic [4:0]       first_fail_idx,
  output logic [4:0]       ctrl_ALUopcode,
  output logic [4:0]       ctrl_shiftamt,
  output logic [31:0]      data_operandA,
  output logic [31:0]      data_operandB,
  input  logic [31:0]      data_result,
  input  logic             isNotEqual,
  input  logic             isLessThan,
  input  logic             overflow
);

  localparam logic [3:0]       SettleLast = (SETTLE_CYCLES == 0) ? 4'd0 :
                                            4'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       LastOp     = 3'(NUM_OPS - 1);
  localparam logic [4:0]       LastIdx    = 5'(NUM_IDX - 1);
  localparam logic [ERR_W-1:0] ErrMax     = '1;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [4:0]       opcode_q, opcode_d;
  logic [4:0]       shamt_q, shamt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [4:0]       ffop_q, ffop_d;
  logic [4:0]       ffidx_q, ffidx_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [31:0] exp_result;
  logic        exp_ovf;
  logic        exp_ne;
  logic        exp_lt;
  chk_mask_t   chk_mask;
  logic        mismatch;
  logic        last_vec;

  alu_golden u_golden (
    .opcode_i     (opcode_q),
    .a_i          (a_q),
    .b_i          (b_q),
    .shamt_i      (shamt_q),
    .exp_result_o (exp_result),
    .exp_ovf_o    (exp_ovf),
    .exp_ne_o     (exp_ne),
    .exp_lt_o     (exp_lt),
    .chk_mask_o   (chk_mask)
  );

  assign last_vec = (op_q == LastOp) && (idx_q == LastIdx);

  // Case inequality so an X on a checked field counts as a failure; masked
  // flags are ignored entirely.
  always_comb begin
    mismatch = (data_result !== exp_result) ||
               (chk_mask.ovf && (overflow !== exp_ovf)) ||
               (chk_mask.ne && (isNotEqual !== exp_ne)) ||
               (chk_mask.lt && (isLessThan !== exp_lt));
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StDrive;
      StDrive: state_d = (SETTLE_CYCLES == 0) ? StCheck : StWait;
      StWait:  if (wait_cnt_q == SettleLast) state_d = StCheck;
      StCheck: state_d = last_vec ? StDone : StDrive;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      StDrive, StWait, StCheck: busy = 1'b1;
      default:                  busy = 1'b0;
    endcase
  end

  // Vector generation, result checking and run bookkeeping.
  always_comb begin
    op_d       = op_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    opcode_d   = opcode_q;
    shamt_d    = shamt_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    ffop_d     = ffop_q;
    ffidx_d    = ffidx_q;
    done_d     = done_q;
    pass_d     = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = '0;
          idx_d   = '0;
          err_d   = '0;
          ffop_d  = '0;
          ffidx_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        opcode_d   = {2'b00, op_q};
        shamt_d    = idx_q;
        a_d        = rotl32(SEED_A, idx_q);
        b_d        = rotl32(SEED_B, idx_q);
        wait_cnt_d = '0;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
      StCheck: begin
        if (mismatch) begin
          // err_q is only zero before the first failure of a run.
          if (err_q == '0) begin
            ffop_d  = opcode_q;
            ffidx_d = shamt_q;
          end
          if (err_q != ErrMax) begin
            err_d = err_q + 1'b1;
          end
        end
        if (last_vec) begin
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end else if (idx_q == LastIdx) begin
          idx_d = '0;
          op_d  = op_q + 3'd1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        op_d = op_q;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      shamt_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= '0;
      ffop_q     <= '0;
      ffidx_q    <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      op_q       <= op_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      shamt_q    <= shamt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      ffop_q     <= ffop_d;
      ffidx_q    <= ffidx_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign first_fail_op  = ffop_q;
  assign first_fail_idx = ffidx_q;
  assign ctrl_ALUopcode = opcode_q;
  assign ctrl_shiftamt  = shamt_q;
  assign data_operandA  = a_q;
  assign data_operandB  = b_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: two instances (settle 1 / 8-bit counter, settle 0 /
// 4-bit counter) each facing a behavioural ALU with selectable faults.
module tb_alu_bist;

  localparam logic [31:0] SA = 32'h8000_0001;
  localparam logic [31:0] SB = 32'h7FFF_FFFF;

  typedef struct packed {
    logic        ovf;
    logic        lt;
    logic        ne;
    logic [31:0] res;
  } resp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        pass_s  [2];
  logic [4:0]  ffop_s  [2];
  logic [4:0]  ffidx_s [2];
  logic [4:0]  op_s    [2];
  logic [4:0]  sh_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic [7:0]  err0;
  logic [3:0]  err4;
  int          fault   [2];
  int          set_s   [2];
  resp_t       r0, r1;

  vec_t exp_q[$];
  int   sel;
  int   bcnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
  endfunction

  // Behavioural ALU. Unchecked flags are driven to 1 so a bad mask shows up.
  function automatic resp_t alu_resp(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh, input int f);
    resp_t       r;
    logic [32:0] s;
    r.ovf = 1'b1;
    r.lt  = 1'b1;
    r.ne  = 1'b1;
    r.res = '0;
    case (op)
      5'd0: begin
        s = {a[31], a} + {b[31], b};
        r.res = s[31:0];
        r.ovf = s[32] ^ s[31];
      end
      5'd1: begin
        s = {a[31], a} - {b[31], b};
        r.res = s[31:0];
        r.ovf = s[32] ^ s[31];
        r.lt  = s[32];
        r.ne  = |s;
      end
      5'd2: r.res = a & b;
      5'd3: r.res = a | b;
      5'd4: r.res = a << sh;
      5'd5: r.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      default: r.res = '0;
    endcase
    if (f == 1 && op == 5'd3) r.res[0] = 1'b0;
    if (f == 2) r.ovf = 1'b0;
    if (f == 3) r.res = ~r.res;
    return r;
  endfunction

  assign r0 = alu_resp(op_s[0], a_s[0], b_s[0], sh_s[0], fault[0]);
  assign r1 = alu_resp(op_s[1], a_s[1], b_s[1], sh_s[1], fault[1]);

  alu_bist #(.SETTLE_CYCLES(1), .ERR_W(8)) u_dut0 (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start_s[0]),
    .busy           (busy_s[0]),
    .done           (done_s[0]),
    .pass           (pass_s[0]),
    .error_count    (err0),
    .first_fail_op  (ffop_s[0]),
    .first_fail_idx (ffidx_s[0]),
    .ctrl_ALUopcode (op_s[0]),
    .ctrl_shiftamt  (sh_s[0]),
    .data_operandA  (a_s[0]),
    .data_operandB  (b_s[0]),
    .data_result    (r0.res),
    .isNotEqual     (r0.ne),
    .isLessThan     (r0.lt),
    .overflow       (r0.ovf)
  );

  alu_bist #(.SETTLE_CYCLES(0), .ERR_W(4)) u_dut1 (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start_s[1]),
    .busy           (busy_s[1]),
    .done           (done_s[1]),
    .pass           (pass_s[1]),
    .error_count    (err4),
    .first_fail_op  (ffop_s[1]),
    .first_fail_idx (ffidx_s[1]),
    .ctrl_ALUopcode (op_s[1]),
    .ctrl_shiftamt  (sh_s[1]),
    .data_operandA  (a_s[1]),
    .data_operandB  (b_s[1]),
    .data_result    (r1.res),
    .isNotEqual     (r1.ne),
    .isLessThan     (r1.lt),
    .overflow       (r1.ovf)
  );

  function automatic logic [7:0] get_err(input int i);
    return (i == 0) ? err0 : {4'b0, err4};
  endfunction

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected error count (saturated) and first failing vector for a fault.
  task automatic model_errs(input int f, input int w, output int cnt, output int fop,
                            output int fidx);
    resp_t       g, y;
    logic [31:0] a, b;
    logic        bad;
    cnt  = 0;
    fop  = 0;
    fidx = 0;
    for (int op = 0; op < 6; op++) begin
      for (int idx = 0; idx < 32; idx++) begin
        a   = rl(SA, idx);
        b   = rl(SB, idx);
        g   = alu_resp(5'(op), a, b, 5'(idx), 0);
        y   = alu_resp(5'(op), a, b, 5'(idx), f);
        bad = (g.res !== y.res) || (op < 2 && g.ovf !== y.ovf) ||
              (op == 1 && (g.ne !== y.ne || g.lt !== y.lt));
        if (bad) begin
          if (cnt == 0) begin
            fop  = op;
            fidx = idx;
          end
          cnt++;
        end
      end
    end
    if (cnt > (1 << w) - 1) cnt = (1 << w) - 1;
  endtask

  task automatic push_vectors();
    exp_q.delete();
    for (int op = 0; op < 6; op++) begin
      for (int idx = 0; idx < 32; idx++) begin
        exp_q.push_back({5'(op), 5'(idx), rl(SA, idx), rl(SB, idx)});
      end
    end
  endtask

  // Scoreboard: in each vector's last busy cycle the driven vector is popped and compared.
  always @(negedge clock) begin
    vec_t got, e;
    if (busy_s[sel] === 1'b1) begin
      if ((bcnt % (set_s[sel] + 2)) == set_s[sel] + 1) begin
        chk("vec_available", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          got = {op_s[sel], sh_s[sel], a_s[sel], b_s[sel]};
          chk("vec", got, e);
        end
      end
      bcnt++;
    end
  end

  task automatic run(input int i, input int f, input int repulse_at);
    int s, w, ecnt, efop, efidx;
    s        = set_s[i];
    w        = (i == 0) ? 8 : 4;
    fault[i] = f;
    sel      = i;
    bcnt     = 0;
    push_vectors();
    model_errs(f, w, ecnt, efop, efidx);
    @(negedge clock);
    start_s[i] = 1'b1;
    @(negedge clock);
    start_s[i] = 1'b0;
    chk("busy_after_start", busy_s[i], 1'b1);
    chk("done_cleared", done_s[i], 1'b0);
    for (int c = 0; c < 5000 && done_s[i] !== 1'b1; c++) begin
      start_s[i] = (c == repulse_at);
      @(negedge clock);
    end
    start_s[i] = 1'b0;
    #1;
    chk("done", done_s[i], 1'b1);
    chk("busy_in_done", busy_s[i], 1'b0);
    chk("run_cycles", bcnt, 192 * (s + 2));
    chk("error_count", get_err(i), ecnt);
    chk("pass", pass_s[i], ecnt == 0);
    chk("first_fail_op", ffop_s[i], efop);
    chk("first_fail_idx", ffidx_s[i], efidx);
    chk("vec_queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clock);
    chk("done_held", {done_s[i], pass_s[i], busy_s[i]}, {1'b1, ecnt == 0, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_s      = '{1, 0};
    fault      = '{0, 0};
    start_s    = '{1'b0, 1'b0};
    sel        = 0;
    bcnt       = 0;
    reset_n    = 1'b0;
    #23;
    for (int i = 0; i < 2; i++) begin
      chk("reset_status", {busy_s[i], done_s[i], pass_s[i], get_err(i), ffop_s[i], ffidx_s[i]},
          0);
      chk("reset_vector", {op_s[i], sh_s[i], a_s[i], b_s[i]}, 0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    run(0, 0, -1);  // clean ALU, 576 cycles
    run(0, 1, -1);  // OR bit0 stuck at 0
    run(0, 2, -1);  // overflow forced 0
    run(0, 0, 50);  // start re-pulsed mid-run is ignored
    run(1, 0, -1);  // zero settle cycles, 384 cycles
    run(1, 3, -1);  // inverted result saturates a 4-bit counter

    // Reset 100 cycles into a run aborts at once.
    sel  = 0;
    bcnt = 0;
    push_vectors();
    @(negedge clock);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    repeat (100) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_status", {busy_s[0], done_s[0], pass_s[0], err0, ffop_s[0], ffidx_s[0]}, 0);
    chk("abort_vector", {op_s[0], sh_s[0], a_s[0], b_s[0]}, 0);
    @(negedge clock);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle_after_abort", {busy_s[0], done_s[0]}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
